// File: rtl/xr_pkg.sv
// Shared xriscv definitions: load/store funct3 encodings, lsu state enum, constants.
// The lsu optionally traps misaligned accesses when LSU_MISALIGN_TRAP_EN is defined.
package xr_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] ALL0 = 32'h0000_0000;
  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  function automatic logic f3_illegal(input logic is_load, input logic [2:0] f3);
    if (is_load) return !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    return !(f3 inside {F3_SB, F3_SH, F3_SW});
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering between the lsu and the 32-bit data bus: store byte enables and
// replication, load lane select with sign/zero extension. Purely combinational.
module lsu_align
  import xr_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_sext;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      2'b00: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_off)
      2'b01:   ld_byte = ld_rdata[15:8];
      2'b10:   ld_byte = ld_rdata[23:16];
      2'b11:   ld_byte = ld_rdata[31:24];
      default: ;
    endcase
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    // funct3[2] set means the unsigned variants LBU/LHU
    ld_sext = ~ld_funct3[2];
    case (ld_funct3[1:0])
      2'b00:   ld_data = (ld_sext & ld_byte[7]) ? {ALL1[31:8], ld_byte} : {ALL0[31:8], ld_byte};
      2'b01:   ld_data = (ld_sext & ld_half[15]) ? {ALL1[31:16], ld_half} : {ALL0[31:16], ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// xriscv load/store unit: single-outstanding req/gnt/rvalid data bus master with watchdog.
// Define LSU_MISALIGN_TRAP_EN to abort misaligned half/word accesses with ls_err.
module lsu
  import xr_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        ex_valid,
  input  logic        op_load,
  input  logic        op_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm_signed,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  dest,
  output logic        ls_done,
  output logic        ls_err,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic        d_req,
  output logic        d_we,
  output logic [31:0] d_addr,
  output logic [3:0]  d_be,
  output logic [31:0] d_wdata,
  input  logic        d_gnt,
  input  logic        d_rvalid,
  input  logic [31:0] d_rdata,
  output lsu_state_e  dbg_state
);

  // Bus handshake: d_req and all d_* hold steady from the cycle after accept until
  // d_gnt is sampled high; a load then waits for d_rvalid (earliest the next cycle).
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  dest_q, dest_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        d_req_q, d_req_d, d_we_q, d_we_d;
  logic [31:0] d_addr_q, d_addr_d, d_wdata_q, d_wdata_d;
  logic [3:0]  d_be_q, d_be_d;
  logic        ls_done_q, ls_done_d, ls_err_q, ls_err_d, rd_we_q, rd_we_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_wdata_q, rd_wdata_d;

  logic [31:0] eff, st_wdata, ld_data;
  logic [3:0]  st_be;
  logic        misalign, acc_err, wd_expire;

  assign eff = rs1_val + imm_signed;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((funct3[1:0] == 2'b01) && eff[0]) ||
                    ((funct3[1:0] == 2'b10) && (eff[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign acc_err   = f3_illegal(op_load, funct3) | misalign;
  assign wd_expire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  lsu_align u_align (
    .st_size   (funct3[1:0]),
    .st_off    (eff[1:0]),
    .st_data   (rs2_val),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .ld_rdata  (d_rdata),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    is_load_d  = is_load_q;
    f3_d       = f3_q;
    off_d      = off_q;
    dest_d     = dest_q;
    cnt_d      = cnt_q;
    d_req_d    = d_req_q;
    d_we_d     = d_we_q;
    d_addr_d   = d_addr_q;
    d_be_d     = d_be_q;
    d_wdata_d  = d_wdata_q;
    ls_done_d  = 1'b0;
    ls_err_d   = 1'b0;
    rd_we_d    = 1'b0;
    rd_addr_d  = 5'd0;
    rd_wdata_d = ALL0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid && (op_load || op_store)) begin
          is_load_d = op_load;
          f3_d      = funct3;
          off_d     = eff[1:0];
          dest_d    = dest;
          cnt_d     = '0;
          if (acc_err) begin
            state_d   = ST_DONE;
            ls_done_d = 1'b1;
            ls_err_d  = 1'b1;
          end else begin
            state_d   = ST_REQ;
            d_req_d   = 1'b1;
            d_we_d    = ~op_load;
            d_addr_d  = {eff[31:2], 2'b00};
            d_be_d    = st_be;
            d_wdata_d = op_load ? ALL0 : st_wdata;
          end
        end
      end
      ST_REQ, ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (state_q == ST_REQ && d_gnt) begin
          state_d   = is_load_q ? ST_WAIT : ST_DONE;
          ls_done_d = ~is_load_q;
        end else if (state_q == ST_WAIT && d_rvalid) begin
          state_d   = ST_DONE;
          ls_done_d = 1'b1;
          if (dest_q != 5'd0) begin
            rd_we_d    = 1'b1;
            rd_addr_d  = dest_q;
            rd_wdata_d = ld_data;
          end
        end else if (wd_expire) begin
          state_d   = ST_DONE;
          ls_done_d = 1'b1;
          ls_err_d  = 1'b1;
        end
        // Any exit from REQ (grant or watchdog) releases the bus
        if (state_d != ST_REQ) begin
          d_req_d   = 1'b0;
          d_we_d    = 1'b0;
          d_addr_d  = ALL0;
          d_be_d    = 4'b0000;
          d_wdata_d = ALL0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      is_load_q  <= 1'b0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      dest_q     <= 5'd0;
      cnt_q      <= '0;
      d_req_q    <= 1'b0;
      d_we_q     <= 1'b0;
      d_addr_q   <= ALL0;
      d_be_q     <= 4'b0000;
      d_wdata_q  <= ALL0;
      ls_done_q  <= 1'b0;
      ls_err_q   <= 1'b0;
      rd_we_q    <= 1'b0;
      rd_addr_q  <= 5'd0;
      rd_wdata_q <= ALL0;
    end else begin
      state_q    <= state_d;
      is_load_q  <= is_load_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      dest_q     <= dest_d;
      cnt_q      <= cnt_d;
      d_req_q    <= d_req_d;
      d_we_q     <= d_we_d;
      d_addr_q   <= d_addr_d;
      d_be_q     <= d_be_d;
      d_wdata_q  <= d_wdata_d;
      ls_done_q  <= ls_done_d;
      ls_err_q   <= ls_err_d;
      rd_we_q    <= rd_we_d;
      rd_addr_q  <= rd_addr_d;
      rd_wdata_q <= rd_wdata_d;
    end
  end

  assign ls_done   = ls_done_q;
  assign ls_err    = ls_err_q;
  assign rd_we     = rd_we_q;
  assign rd_addr   = rd_addr_q;
  assign rd_wdata  = rd_wdata_q;
  assign d_req     = d_req_q;
  assign d_we      = d_we_q;
  assign d_addr    = d_addr_q;
  assign d_be      = d_be_q;
  assign d_wdata   = d_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: a transaction-level model drives the bus and predicts every output cycle by cycle.
// Built with TIMEOUT=4 so watchdog aborts occur naturally under random grant/rvalid delays.
`timescale 1ns/1ps
module tb_lsu;
  import xr_pkg::*;

  localparam int TO = 4;

  logic        clk, rstb;
  logic        ex_valid, op_load, op_store;
  logic [2:0]  funct3;
  logic [31:0] imm_signed, rs1_val, rs2_val;
  logic [4:0]  dest;
  logic        ls_done, ls_err, rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  lsu_state_e  dbg_state;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstb(rstb), .ex_valid(ex_valid), .op_load(op_load), .op_store(op_store),
    .funct3(funct3), .imm_signed(imm_signed), .rs1_val(rs1_val), .rs2_val(rs2_val), .dest(dest),
    .ls_done(ls_done), .ls_err(ls_err), .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic        exp_done, exp_err, exp_rd_we, exp_req, exp_we;
  logic [4:0]  exp_rd_addr;
  logic [31:0] exp_rd_wdata, exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("ls_done", 32'(ls_done), 32'(exp_done));
    chk("ls_err", 32'(ls_err), 32'(exp_err));
    chk("rd_we", 32'(rd_we), 32'(exp_rd_we));
    chk("rd_addr", 32'(rd_addr), 32'(exp_rd_addr));
    chk("rd_wdata", rd_wdata, exp_rd_wdata);
    chk("d_req", 32'(d_req), 32'(exp_req));
    if (exp_req || !rstb) begin
      chk("d_we", 32'(d_we), 32'(exp_we));
      chk("d_addr", d_addr, exp_addr);
      chk("d_be", 32'(d_be), 32'(exp_be));
    end
    if ((exp_req && exp_we) || !rstb) chk("d_wdata", d_wdata, exp_wdata);
  end

  // ---------------- behavioural model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int m_start(input logic [2:0] f3, input logic [31:0] eff);
    int lo;
    lo = int'(eff[1:0]);
    return lo - (lo % m_size(f3));
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] eff);
    return 4'(((1 << m_size(f3)) - 1) << m_start(f3, eff));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % m_size(f3)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] eff,
                                         input logic [31:0] rdata);
    longint v;
    int     bits;
    bits = 8 * m_size(f3);
    if (bits == 32) return rdata;
    v = longint'(rdata >> (8 * m_start(f3, eff))) & ((64'd1 << bits) - 1);
    if (!f3[2] && v[bits-1]) v = v - (64'sd1 <<< bits);
    return v[31:0];
  endfunction

  function automatic bit m_err(input bit ld, input logic [2:0] f3, input logic [31:0] eff);
    bit bad;
    if (ld) bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else    bad = (f3 > 3'd2);
`ifdef LSU_MISALIGN_TRAP_EN
    if (!bad && m_start(f3, eff) != int'(eff[1:0])) bad = 1'b1;
`endif
    return bad;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp_idle();
    exp_done = 0; exp_err = 0; exp_rd_we = 0; exp_rd_addr = '0; exp_rd_wdata = '0;
    exp_req = 0; exp_we = 0; exp_addr = '0; exp_be = '0; exp_wdata = '0;
  endtask

  // Inputs that the unit must ignore while a transaction is in flight
  task automatic noise();
    ex_valid = 1'($urandom_range(0, 1));
    op_load  = 1'($urandom_range(0, 1));
    op_store = 1'($urandom_range(0, 1));
    funct3   = 3'($urandom);
    rs1_val  = $urandom;
    imm_signed = $urandom;
    rs2_val  = $urandom;
    dest     = 5'($urandom);
    d_rdata  = $urandom;
  endtask

  task automatic end_access();
    set_exp_idle();
    ex_valid = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      op_load = 0;
      op_store = 0;
      step();
    end
    ex_valid = 0;
  endtask

  task automatic do_access(input bit ld, input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] imm, input logic [31:0] rs2, input logic [4:0] dst,
                           input int gnt_wait, input int rv_wait, input logic [31:0] rdata);
    logic [31:0] eff;
    int k, j;
    bit granted, got;
    eff = rs1 + imm;
    ex_valid = 1; op_load = ld; op_store = !ld; funct3 = f3;
    rs1_val = rs1; imm_signed = imm; rs2_val = rs2; dest = dst;
    step();
    noise();
    if (m_err(ld, f3, eff)) begin
      exp_done = 1; exp_err = 1;
      step();
      end_access();
      return;
    end
    k = 0;
    granted = 0;
    forever begin
      k++;
      exp_req = 1; exp_we = !ld; exp_addr = {eff[31:2], 2'b00};
      exp_be = m_be(f3, eff); exp_wdata = m_wdata(f3, rs2);
      granted = (k > gnt_wait);
      d_gnt = granted;
      step();
      d_gnt = 0;
      noise();
      set_exp_idle();
      if (granted || (TO != 0 && k == TO)) break;
    end
    if (!granted || !ld) begin
      exp_done = 1; exp_err = !granted;
      step();
      end_access();
      return;
    end
    j = 0;
    forever begin
      k++;
      got = (j >= rv_wait);
      d_rvalid = got;
      if (got) d_rdata = rdata;
      step();
      d_rvalid = 0;
      noise();
      if (got) begin
        exp_done = 1;
        exp_rd_we = (dst != 0);
        if (dst != 0) begin
          exp_rd_addr = dst;
          exp_rd_wdata = m_load(f3, eff, rdata);
        end
        step();
        end_access();
        return;
      end
      if (TO != 0 && k == TO) begin
        exp_done = 1; exp_err = 1;
        step();
        end_access();
        return;
      end
      j++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ld;
    logic [2:0] f3;
    logic [2:0] legal_ld [5];
    logic [31:0] imm;
    legal_ld = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};

    rstb = 0; ex_valid = 0; op_load = 0; op_store = 0; funct3 = 0;
    imm_signed = 0; rs1_val = 0; rs2_val = 0; dest = 0;
    d_gnt = 0; d_rvalid = 0; d_rdata = 0;
    set_exp_idle();
    step(); step(); step();
    rstb = 1;
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));

    // Hand-computed pins on the model itself
    chk("pin_be_byte3", 32'(m_be(F3_LB, 32'h103)), 32'h8);
    chk("pin_be_half_hi", 32'(m_be(F3_SH, 32'h102)), 32'hC);
    chk("pin_be_word", 32'(m_be(F3_SW, 32'h104)), 32'hF);
    chk("pin_wdata_sh", m_wdata(F3_SH, 32'hAAAA1234), 32'h12341234);
    chk("pin_wdata_sb", m_wdata(F3_SB, 32'h000000A5), 32'hA5A5A5A5);
    chk("pin_load_lb", m_load(F3_LB, 32'h103, 32'h80112233), 32'hFFFFFF80);
    chk("pin_load_lbu", m_load(F3_LBU, 32'h103, 32'h80112233), 32'h00000080);
    chk("pin_load_lh", m_load(F3_LH, 32'h102, 32'h80112233), 32'hFFFF8011);

    // Directed cases
    do_access(0, F3_SW, 32'h100, 32'h4, 32'hDEADBEEF, 5'd1, 0, 0, 0);
    do_access(1, F3_LB, 32'h100, 32'h3, 0, 5'd5, 0, 0, 32'h80112233);
    do_access(1, F3_LBU, 32'h100, 32'h3, 0, 5'd6, 0, 0, 32'h80112233);
    do_access(0, F3_SH, 32'h100, 32'h2, 32'hAAAA1234, 5'd0, 3, 0, 0);
    do_access(1, F3_LW, 32'h100, 32'h1, 0, 5'd7, 0, 0, 32'hCAFEF00D);
    do_access(1, 3'b011, 32'h40, 32'h0, 0, 5'd8, 0, 0, 0);
    do_access(0, 3'b100, 32'h40, 32'h0, 32'h1, 5'd8, 0, 0, 0);

    // Watchdog abort, a late rvalid that must be ignored, then a clean load
    do_access(1, F3_LW, 32'h200, 32'h0, 0, 5'd4, 100, 0, 0);
    d_rvalid = 1; d_rdata = 32'h55AA55AA;
    step();
    d_rvalid = 0;
    do_access(1, F3_LH, 32'h300, 32'h2, 0, 5'd4, 0, 1, 32'h9ABC1234);

    // Reset while waiting for load data; rvalid after release must not complete anything
    ex_valid = 1; op_load = 1; op_store = 0; funct3 = F3_LW;
    rs1_val = 32'h200; imm_signed = 0; dest = 5'd9;
    step();
    ex_valid = 0;
    exp_req = 1; exp_we = 0; exp_addr = 32'h200; exp_be = 4'hF;
    d_gnt = 1;
    step();
    d_gnt = 0;
    set_exp_idle();
    rstb = 0;
    step(); step();
    rstb = 1;
    d_rvalid = 1; d_rdata = 32'h12345678;
    step();
    d_rvalid = 0;
    step();
    do_access(1, F3_LW, 32'h400, 32'h0, 0, 5'd0, 0, 0, 32'h0BADF00D);

    // Randomized traffic, back-to-back and with idle gaps
    for (int t = 0; t < 300; t++) begin
      ld = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
      else if (ld) f3 = legal_ld[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 2));
      imm = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : $urandom;
      do_access(ld, f3, $urandom, imm, $urandom, 5'($urandom),
                ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit of the xriscv core, directly downstream of the fetch/decode stage. It takes decoded load/store instructions and their register operands and runs a single-outstanding request/grant/rvalid transaction on the data bus. Loads are returned to the register file with byte/halfword alignment and sign/zero extension. It raises `ls_done` to release the fetcher's load/store stall.

## Interface
- `TIMEOUT`, 255: bus watchdog limit in cycles spent in REQ+WAIT; 0 disables the watchdog.
- `clk`  in  1  clock
- `rstb`  in  1  reset, asynchronous, active-low
- `ex_valid`  in  1  decoded instruction valid this cycle
- `op_load`, `op_store`  in  1  decoded opcode flags
- `funct3`  in  3  access size/sign
- `imm_signed`  in  32  offset
- `rs1_val`  in  32  base register value
- `rs2_val`  in  32  store data
- `dest`  in  5  load destination register
- `ls_done`  out  1  one-cycle completion pulse
- `ls_err`  out  1  qualifies `ls_done`: access aborted, no register write
- `rd_we`  out  1  register write strobe
- `rd_addr`  out  5  register write index
- `rd_wdata`  out  32  register write data
- `d_req`  out  1  bus request
- `d_we`  out  1  1 = store
- `d_addr`  out  32  word-aligned address
- `d_be`  out  4  byte enables
- `d_wdata`  out  32  lane-replicated store data
- `d_gnt`  in  1  request accepted
- `d_rvalid`  in  1  load data valid
- `d_rdata`  in  32  load data

## Operation
- Reset value of every output: 0. Reset state is IDLE; the watchdog counter resets to 0.
- States:
  - IDLE: accept when `ex_valid & (op_load|op_store)`. Latch `eff = rs1_val + imm_signed` (mod 2^32), `funct3`, `dest`, `rs2_val` and the direction. Go to REQ, or to DONE on an error.
  - REQ: hold `d_req` and all `d_*` outputs stable until `d_gnt`. Store then goes to DONE; load goes to WAIT.
  - WAIT: `d_req` = 0. Go to DONE on `d_rvalid`.
  - DONE: pulse `ls_done` for one cycle, then go to IDLE.
- Accept inputs are ignored outside IDLE; the fetcher stalls upstream.
- Address and lanes:
  - `d_addr = {eff[31:2],2'b00}`.
  - Byte (funct3 x00): `d_be = 1<<eff[1:0]`; store data byte replicated x4.
  - Half (x01): `d_be` = 0011 when `eff[1]`=0, 1100 otherwise; store data halfword replicated x2.
  - Word (010): `d_be` = 1111.
- Load return:
  - Select the lane by `eff[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - `rd_we` = 1 with `ls_done` unless `dest` = 0 or `ls_err`.
  - `rd_addr`/`rd_wdata` are valid while `rd_we` = 1 and are 0 otherwise.
- Invalid funct3:
  - Load 011/110/111; store 011 and above.
  - No bus access; DONE with `ls_err` = 1.
- Watchdog, when `TIMEOUT` ≠ 0:
  - Counts cycles in REQ/WAIT.
  - On reaching `TIMEOUT`: drop `d_req`, go to DONE with `ls_err` = 1. A late `d_rvalid` is ignored in IDLE.
- Reset mid-transaction: return to IDLE immediately with all outputs 0. No completion is reported.

## Timing
- Accept at cycle N: `d_req` = 1 at N+1.
- `d_gnt` sampled at cycle G:
  - Store: `ls_done` at G+1.
  - Load: WAIT from G+1. `d_rvalid` is accepted at G+1 at the earliest; `d_rvalid` at R gives `ls_done`/`rd_we` at R+1.
- Minimum latency, accept to `ls_done`: store 2 cycles, load 3 cycles.
- Error path (invalid funct3 or misalignment trap): `ls_done`+`ls_err` at N+1, `d_req` never asserted.
- Back-to-back: a new accept is possible in the cycle after `ls_done`.

## Configuration
- `LSU_MISALIGN_TRAP_EN`:
  - Defined: a half access with `eff[0]`=1 or a word access with `eff[1:0]`≠0 is misaligned. It is not issued; DONE with `ls_err` = 1.
  - Undefined: offending low bits are ignored. Half uses `eff[1]` only, word uses the aligned word, no error.

## Structure
- Shared package `xr_pkg`: funct3 load/store encodings (LB…SW), the lsu state enum, and `ALL0`/`ALL1` constants.
- Sub-module `lsu_align`: combinational. Store lane replication plus `d_be`; load lane select plus extension.
- FSM, latches and watchdog stay in `lsu`.

## Test plan
- SW, rs1 0x100, imm 4, rs2 0xDEADBEEF, `d_gnt` at N+1 → `d_addr` 0x104, `d_be` 1111, `d_wdata` 0xDEADBEEF; `ls_done` at N+2, `rd_we` = 0.
- LB and LBU at eff 0x103, `d_rdata` 0x80112233, `d_rvalid` one cycle after grant → `d_be` 1000; `rd_wdata` 0xFFFFFF80 (LB) and 0x00000080 (LBU).
- SH, eff 0x102, rs2 0xAAAA1234 → `d_be` 1100, `d_wdata` 0x12341234; `d_gnt` delayed 3 cycles → `d_req` held and `d_*` stable throughout.
- LW eff 0x101 → with macro: `ls_done`+`ls_err` at N+1, no `d_req`; without: `d_addr` 0x100, normal completion.
- `TIMEOUT`=4, `d_gnt` held 0 → `d_req` high 4 cycles, then `ls_done`+`ls_err`, `rd_we` = 0; next load completes normally.
- `rstb` asserted in WAIT, then `d_rvalid` after release → all outputs 0, no `ls_done`; LW to x0 completes with `ls_done` and `rd_we` = 0.
